// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared constants, opcode and FSM encodings for the SPI register memory
package spi_mem_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int OPC_W  = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_WRITE  = 3'b001,
        OP_READ   = 3'b010,
        OP_BWRITE = 3'b011,
        OP_BREAD  = 3'b100
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE
    } state_t;

    function automatic logic is_write(input logic [OPC_W-1:0] op);
        return op == OP_WRITE || op == OP_BWRITE;
    endfunction

    function automatic logic is_read(input logic [OPC_W-1:0] op);
        return op == OP_READ || op == OP_BREAD;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with rise/fall pulses, edges masked until the chain holds real samples
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES:0] s;
    logic [STAGES:0] vld;

    assign q    = s[STAGES-1];
    assign rise = vld[STAGES] & q & ~s[STAGES];
    assign fall = vld[STAGES] & ~q & s[STAGES];

    // shift the pin through the chain; vld marks when the edge-detect pair no longer holds reset values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s   <= {(STAGES + 1){RST_VAL}};
            vld <= '0;
        end else begin
            s   <= {s[STAGES-1:0], d};
            vld <= {vld[STAGES-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/spi_slave_mem.sv
// spi_slave_mem: oversampled SPI slave decoding opcode/address frames into a 32x8 flop memory
module spi_slave_mem #(
    parameter int ADDR_W      = spi_mem_pkg::ADDR_W,
    parameter int DATA_W      = spi_mem_pkg::DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cs,
    input  logic sclk,
    input  logic mosi,
    output logic miso,
    output logic busy,
    output logic cmd_err
);

    import spi_mem_pkg::*;

    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [2:0] CMD_LAST  = 3'(OPC_W - 1);
    localparam logic [2:0] ADDR_LAST = 3'(ADDR_W - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_W - 1);

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [OPC_W-1:0]  opc, opc_n;
    logic [ADDR_W-1:0] addr, addr_n, addr_in, addr_inc;
    logic [DATA_W-1:0] sh, sh_n;
    logic              armed, armed_n, err_n, we;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [SYNC_STAGES:0] mosi_s;
    logic mosi_d, cs_q, cs_rise, cs_fall, sclk_q, sclk_rise, sclk_fall, unused_sclk;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sclk),
        .q    (sclk_q),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // cs idles high, so its chain resets high to keep busy low out of reset
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (cs),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    assign mosi_d      = mosi_s[SYNC_STAGES];
    assign addr_in     = {addr[ADDR_W-2:0], mosi_d};
    assign addr_inc    = addr + ADDR_W'(1);
    assign miso        = (state == ST_RDATA) && sh[DATA_W-1];
    assign unused_sclk = sclk_q ^ sclk_fall;

    // next-state decode; a cs rise overrides any sclk edge seen in the same cycle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        opc_n   = opc;
        addr_n  = addr;
        sh_n    = sh;
        armed_n = armed | cs_fall;
        err_n   = 1'b0;
        we      = 1'b0;
        if (cs_rise) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            armed_n = 1'b0;
        end else if (sclk_rise) begin
            cnt_n = cnt + 3'd1;
            case (state)
                ST_IDLE: begin
                    cnt_n = '0;
                    if (armed) begin
                        state_n = ST_CMD;
                        armed_n = 1'b0;
                    end
                end
                ST_CMD: begin
                    opc_n = {opc[OPC_W-2:0], mosi_d};
                    if (cnt == CMD_LAST) begin
                        state_n = ST_ADDR;
                        cnt_n   = '0;
                    end
                end
                ST_ADDR: begin
                    addr_n = addr_in;
                    if (cnt == ADDR_LAST) begin
                        cnt_n = '0;
                        if (is_write(opc)) begin
                            state_n = ST_WDATA;
                        end else if (is_read(opc)) begin
                            state_n = ST_RDATA;
                            sh_n    = mem[addr_in];
                        end else begin
                            state_n = ST_IGNORE;
                            err_n   = 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    sh_n = {sh[DATA_W-2:0], mosi_d};
                    if (cnt == DATA_LAST) begin
                        we = 1'b1;
                        if (opc == OP_WRITE || addr == '1) state_n = ST_IGNORE;
                        else addr_n = addr_inc;
                    end
                end
                ST_RDATA: begin
                    sh_n = {sh[DATA_W-2:0], 1'b0};
                    if (cnt == DATA_LAST) begin
                        if (opc == OP_READ || addr == '1) begin
                            state_n = ST_IGNORE;
                        end else begin
                            addr_n = addr_inc;
                            sh_n   = mem[addr_inc];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            opc     <= '0;
            addr    <= '0;
            sh      <= '0;
            armed   <= 1'b0;
            busy    <= 1'b0;
            cmd_err <= 1'b0;
            mosi_s  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            opc     <= opc_n;
            addr    <= addr_n;
            sh      <= sh_n;
            armed   <= armed_n;
            busy    <= ~cs_q;
            cmd_err <= err_n;
            mosi_s  <= {mosi_s[SYNC_STAGES-1:0], mosi};
        end
    end

    // register memory; a byte commits on the edge that captures its last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[addr] <= sh_n;
        end
    end

endmodule

// File: tb/tb_spi_slave_mem.sv
// tb_spi_slave_mem: directed SPI frames checked against a frame-level memory model
module tb_spi_slave_mem;

    localparam int HALF = 6;

    logic clk = 1'b0, rst_n = 1'b0, cs = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic miso, busy, cmd_err;

    int checks = 0, errors = 0;
    int err_cnt = 0;
    logic err_prev = 1'b0;
    logic exp_valid = 1'b0, exp_miso = 1'b0;
    logic [2:0] cs_hist = 3'b111;

    logic [7:0] mdl [32];
    logic [7:0] txb [32];
    logic       rxbits [300];
    logic [7:0] bw [16] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h12, 8'h34,
                            8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hAB, 8'hCD};
    logic [7:0] low4 [4] = '{8'h00, 8'h01, 8'h00, 8'h00};
    int e0;

    spi_slave_mem dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cs     (cs),
        .sclk   (sclk),
        .mosi   (mosi),
        .miso   (miso),
        .busy   (busy),
        .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // busy follows the pin cs three clocks late and is forced low by reset
    always @(posedge clk) cs_hist <= {cs_hist[1:0], rst_n ? cs : 1'b1};

    always @(negedge clk) begin
        chk("busy", busy, rst_n && !cs_hist[2]);
        if (exp_valid) chk("miso", miso, exp_miso);
        if (cmd_err) begin
            chk("cmd_err_width", err_prev, 0);
            err_cnt++;
        end
        err_prev = cmd_err;
    end

    // bit j is the miso value after the j-th data-carrying rising edge (opcode bits are j=0..2)
    function automatic logic exp_bit(input logic [7:0] hdr, input int j);
        logic [2:0] op;
        int a, b;
        op = hdr[7:5];
        a  = int'(hdr[4:0]);
        if (j < 7 || !(op == 3'b010 || op == 3'b100)) return 1'b0;
        b = (j - 7) / 8;
        if ((op == 3'b010 && b > 0) || a + b > 31) return 1'b0;
        return mdl[a + b][7 - (j - 7) % 8];
    endfunction

    function automatic logic [7:0] rxb(input int b);
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[6:0], rxbits[7 + 8 * b + i]};
        return v;
    endfunction

    task automatic frame(input logic [7:0] hdr, input int ndata, input int rst_at);
        logic s[$];
        logic [2:0] op = hdr[7:5];
        int a = int'(hdr[4:0]);
        int n = 8 + ndata;
        int e_start = err_cnt;
        bit aborted = 0;
        for (int i = 7; i >= 0; i--) s.push_back(hdr[i]);
        for (int b = 0; b < (ndata + 7) / 8; b++)
            for (int i = 7; i >= 0; i--) s.push_back(txb[b][i]);
        cs = 1'b0;
        wclk(HALF);
        sclk = 1'b1; exp_valid = 1'b0;
        wclk(2);
        mosi = s[0];
        wclk(HALF - 2);
        sclk = 1'b0; exp_miso = 1'b0; exp_valid = 1'b1;
        wclk(HALF);
        for (int k = 0; k < n; k++) begin
            if (rst_at >= 0 && k == 8 + rst_at) begin
                rst_n = 1'b0;
                wclk(1);
                chk("rst_miso", miso, 0);
                chk("rst_busy", busy, 0);
                wclk(2);
                rst_n = 1'b1;
                aborted = 1;
                break;
            end
            sclk = 1'b1; exp_valid = 1'b0;
            wclk(2);
            mosi = (k + 1 < n) ? s[k + 1] : 1'b0;
            wclk(HALF - 2);
            sclk = 1'b0;
            exp_miso = exp_bit(hdr, k);
            exp_valid = 1'b1;
            rxbits[k] = miso;
            wclk(HALF);
        end
        wclk(2);
        cs = 1'b1; exp_valid = 1'b0;
        wclk(8);
        exp_miso = 1'b0; exp_valid = 1'b1;
        chk("cmd_err_count", err_cnt - e_start, (op inside {3'b001, 3'b010, 3'b011, 3'b100}) ? 0 : 1);
        if (aborted) begin
            for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
        end else if (op == 3'b001 && ndata >= 8) begin
            mdl[a] = txb[0];
        end else if (op == 3'b011) begin
            for (int b = 0; b < ndata / 8; b++) if (a + b <= 31) mdl[a + b] = txb[b];
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
        wclk(3);
        chk("reset_miso", miso, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cmd_err", cmd_err, 0);
        rst_n = 1'b1;
        wclk(5);
        exp_miso = 1'b0; exp_valid = 1'b1;

        txb[0] = 8'h01;
        frame(8'h21, 8, -1);
        frame(8'h41, 8, -1);
        chk("read_0x01", rxb(0), 8'h01);

        for (int i = 0; i < 16; i++) txb[i] = bw[i];
        frame(8'h70, 128, -1);
        frame(8'h90, 128, -1);
        for (int i = 0; i < 16; i++) chk($sformatf("bread_0x10_b%0d", i), rxb(i), bw[i]);

        for (int i = 0; i < 8; i++) txb[i] = 8'(8'h11 * (i + 1));
        frame(8'h7C, 64, -1);
        frame(8'h9E, 24, -1);
        chk("bread_end_b0", rxb(0), 8'h33);
        chk("bread_end_b1", rxb(1), 8'h44);
        chk("bread_end_b2", rxb(2), 8'h00);
        frame(8'h80, 32, -1);
        for (int i = 0; i < 4; i++) chk($sformatf("no_wrap_b%0d", i), rxb(i), low4[i]);

        txb[0] = 8'h55;
        e0 = err_cnt;
        frame(8'hE2, 8, -1);
        chk("invalid_pulses", err_cnt - e0, 1);
        frame(8'h42, 8, -1);
        chk("invalid_mem02", rxb(0), 8'h00);

        txb[0] = 8'hAA;
        frame(8'h25, 4, -1);
        chk("cut_busy", busy, 0);
        frame(8'h45, 8, -1);
        chk("cut_mem05", rxb(0), 8'h00);
        txb[0] = 8'h5A;
        frame(8'h25, 8, -1);
        frame(8'h45, 8, -1);
        chk("rewrite_mem05", rxb(0), 8'h5A);

        txb[0] = 8'hC1; txb[1] = 8'hC2; txb[2] = 8'hC3;
        frame(8'h60, 24, 16);
        frame(8'h40, 8, -1);
        chk("rst_mem00", rxb(0), 8'h00);
        frame(8'h41, 8, -1);
        chk("rst_mem01", rxb(0), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
